// File: rtl/wb_bus_pkg.sv
// Shared types and constants for the Wishbone address decoder / bus watchdog.
package wb_bus_pkg;

   localparam int unsigned WB_AW   = 32;
   localparam int unsigned WB_DW   = 32;
   localparam int unsigned WB_SELW = 4;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWait,
      StErr
   } wb_state_e;

   // Width of a slave index; never zero so a single-slave build still has a port.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wb_addr_match.sv
// Combinational NS-way address match with lowest-index priority.
module wb_addr_match
   import wb_bus_pkg::*;
#(
   parameter int unsigned             NS         = 4,
   parameter logic [NS*WB_AW-1:0]     SLAVE_BASE = '0,
   parameter logic [NS*WB_AW-1:0]     SLAVE_MASK = '0,
   parameter int unsigned             IdxW       = idx_width(NS)
) (
   input  logic [WB_AW-1:0] addr_i,
   output logic             valid_o,
   output logic [IdxW-1:0]  idx_o
);

   // Scan high to low so the lowest matching slave is the last to assign.
   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      for (int k = int'(NS) - 1; k >= 0; k--) begin
         if ((addr_i & SLAVE_MASK[k*WB_AW +: WB_AW]) == SLAVE_BASE[k*WB_AW +: WB_AW]) begin
            valid_o = 1'b1;
            idx_o   = IdxW'(k);
         end
      end
   end

endmodule

// File: rtl/wb_bus_decoder.sv
// Single-master pipelined Wishbone decoder with per-transaction watchdog.
module wb_bus_decoder
   import wb_bus_pkg::*;
#(
   parameter int unsigned         NS         = 4,
   parameter logic [NS*32-1:0]    SLAVE_BASE = {32'h3000_0000, 32'h2000_0000,
                                                32'h1000_0000, 32'h0000_0000},
   parameter logic [NS*32-1:0]    SLAVE_MASK = {4{32'hF000_0000}},
   parameter int unsigned         TIMEOUT    = 1023
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_wb_cyc,
   input  logic                 i_wb_stb,
   input  logic                 i_wb_we,
   input  logic [WB_AW-1:0]     i_wb_addr,
   input  logic [WB_DW-1:0]     i_wb_data,
   input  logic [WB_SELW-1:0]   i_wb_sel,
   output logic                 o_wb_stall,
   output logic                 o_wb_ack,
   output logic                 o_wb_err,
   output logic [WB_DW-1:0]     o_wb_data,
   output logic [NS-1:0]        o_s_cyc,
   output logic [NS-1:0]        o_s_stb,
   output logic                 o_s_we,
   output logic [WB_AW-1:0]     o_s_addr,
   output logic [WB_DW-1:0]     o_s_data,
   output logic [WB_SELW-1:0]   o_s_sel,
   input  logic [NS-1:0]        i_s_stall,
   input  logic [NS-1:0]        i_s_ack,
   input  logic [NS-1:0]        i_s_err,
   input  logic [NS*WB_DW-1:0]  i_s_data,
   output logic                 o_timeout
);

   localparam int unsigned IdxW = idx_width(NS);
   localparam int unsigned TmrW = $clog2(TIMEOUT + 1);

   wb_state_e            state_q, state_d;
   logic [NS-1:0]        s_cyc_q, s_cyc_d, s_stb_q, s_stb_d;
   logic                 s_we_q, s_we_d;
   logic [WB_AW-1:0]     s_addr_q, s_addr_d;
   logic [WB_DW-1:0]     s_data_q, s_data_d;
   logic [WB_SELW-1:0]   s_sel_q, s_sel_d;
   logic                 ack_q, ack_d, err_q, err_d, tmo_q, tmo_d;
   logic [WB_DW-1:0]     rdata_q, rdata_d;
   logic [TmrW-1:0]      timer_q, timer_d;
   logic [IdxW-1:0]      idx_q, idx_d;

   logic                 match_valid;
   logic [IdxW-1:0]      match_idx;
   logic [NS-1:0]        match_onehot;
   logic                 sel_stall, sel_ack, sel_err;
   logic [WB_DW-1:0]     sel_rdata;

   wb_addr_match #(
      .NS         (NS),
      .SLAVE_BASE (SLAVE_BASE),
      .SLAVE_MASK (SLAVE_MASK),
      .IdxW       (IdxW)
   ) u_match (
      .addr_i  (i_wb_addr),
      .valid_o (match_valid),
      .idx_o   (match_idx)
   );

   // Response mux: only the slave latched at request time is observed.
   always_comb begin
      sel_stall    = 1'b0;
      sel_ack      = 1'b0;
      sel_err      = 1'b0;
      sel_rdata    = '0;
      match_onehot = '0;
      for (int k = 0; k < int'(NS); k++) begin
         match_onehot[k] = match_valid && (match_idx == IdxW'(k));
         if (idx_q == IdxW'(k)) begin
            sel_stall = i_s_stall[k];
            sel_ack   = i_s_ack[k];
            sel_err   = i_s_err[k];
            sel_rdata = i_s_data[k*WB_DW +: WB_DW];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      s_cyc_d  = s_cyc_q;
      s_stb_d  = s_stb_q;
      s_we_d   = s_we_q;
      s_addr_d = s_addr_q;
      s_data_d = s_data_q;
      s_sel_d  = s_sel_q;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      tmo_d    = 1'b0;
      rdata_d  = rdata_q;
      timer_d  = timer_q;
      idx_d    = idx_q;

      unique case (state_q)
         StIdle: begin
            s_cyc_d = '0;
            s_stb_d = '0;
            if (i_wb_cyc && i_wb_stb) begin
               s_we_d   = i_wb_we;
               s_addr_d = i_wb_addr;
               s_data_d = i_wb_data;
               s_sel_d  = i_wb_sel;
               if (match_valid) begin
                  idx_d   = match_idx;
                  s_cyc_d = match_onehot;
                  s_stb_d = match_onehot;
                  timer_d = TmrW'(TIMEOUT);
                  state_d = StReq;
               end else begin
                  err_d   = 1'b1;
                  state_d = StErr;
               end
            end
         end
         StReq, StWait: begin
            if (!i_wb_cyc || sel_err || sel_ack || timer_q == TmrW'(1)) begin
               s_cyc_d = '0;
               s_stb_d = '0;
               timer_d = '0;
               state_d = StIdle;
               if (!i_wb_cyc) begin
                  // Master abort: silently drop the transaction.
               end else if (sel_err) begin
                  err_d = 1'b1;
               end else if (sel_ack) begin
                  ack_d   = 1'b1;
                  rdata_d = sel_rdata;
               end else begin
                  err_d = 1'b1;
                  tmo_d = 1'b1;
               end
            end else begin
               timer_d = timer_q - TmrW'(1);
               if (state_q == StReq && !sel_stall) begin
                  s_stb_d = '0;
                  state_d = StWait;
               end
            end
         end
         StErr: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q  <= StIdle;
         s_cyc_q  <= '0;
         s_stb_q  <= '0;
         s_we_q   <= 1'b0;
         s_addr_q <= '0;
         s_data_q <= '0;
         s_sel_q  <= '0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         tmo_q    <= 1'b0;
         rdata_q  <= '0;
         timer_q  <= '0;
         idx_q    <= '0;
      end else begin
         state_q  <= state_d;
         s_cyc_q  <= s_cyc_d;
         s_stb_q  <= s_stb_d;
         s_we_q   <= s_we_d;
         s_addr_q <= s_addr_d;
         s_data_q <= s_data_d;
         s_sel_q  <= s_sel_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         tmo_q    <= tmo_d;
         rdata_q  <= rdata_d;
         timer_q  <= timer_d;
         idx_q    <= idx_d;
      end
   end

   assign o_wb_stall = (state_q != StIdle);
   assign o_wb_ack   = ack_q;
   assign o_wb_err   = err_q;
   assign o_wb_data  = rdata_q;
   assign o_s_cyc    = s_cyc_q;
   assign o_s_stb    = s_stb_q;
   assign o_s_we     = s_we_q;
   assign o_s_addr   = s_addr_q;
   assign o_s_data   = s_data_q;
   assign o_s_sel    = s_sel_q;
   assign o_timeout  = tmo_q;

endmodule

// File: tb/tb_wb_bus_decoder.sv
// Directed bench for wb_bus_decoder: latency, stall, unmapped, timeout, abort, priority cases.
module tb_wb_bus_decoder;

   logic          clk = 1'b0;
   logic          rst;
   logic          cyc, stb, we;
   logic [31:0]   addr, wdata;
   logic [3:0]    sel;
   logic          wb_stall, wb_ack, wb_err, tmo;
   logic [31:0]   wb_rdata;
   logic [3:0]    s_cyc, s_stb;
   logic          s_we;
   logic [31:0]   s_addr, s_wdata;
   logic [3:0]    s_sel;
   logic [3:0]    s_stall, s_ack, s_err;
   logic [127:0]  s_rdata;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   wb_bus_decoder #(
      .NS         (4),
      .SLAVE_BASE ({32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
      .SLAVE_MASK ({4{32'hF000_0000}}),
      .TIMEOUT    (8)
   ) dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .i_wb_cyc   (cyc),
      .i_wb_stb   (stb),
      .i_wb_we    (we),
      .i_wb_addr  (addr),
      .i_wb_data  (wdata),
      .i_wb_sel   (sel),
      .o_wb_stall (wb_stall),
      .o_wb_ack   (wb_ack),
      .o_wb_err   (wb_err),
      .o_wb_data  (wb_rdata),
      .o_s_cyc    (s_cyc),
      .o_s_stb    (s_stb),
      .o_s_we     (s_we),
      .o_s_addr   (s_addr),
      .o_s_data   (s_wdata),
      .o_s_sel    (s_sel),
      .i_s_stall  (s_stall),
      .i_s_ack    (s_ack),
      .i_s_err    (s_err),
      .i_s_data   (s_rdata),
      .o_timeout  (tmo)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Presents a request for one cycle (cycle N); returns in cycle N+1 with stb low.
   task automatic req(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s);
      cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
      tick();
      stb = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = '0;
      s_stall = '0; s_ack = '0; s_err = '0; s_rdata = '0;
      tick();
      tick();
      check("rst_cyc",   {28'd0, s_cyc}, 32'h0);
      check("rst_stb",   {28'd0, s_stb}, 32'h0);
      check("rst_ack",   {31'd0, wb_ack}, 32'h0);
      check("rst_err",   {31'd0, wb_err}, 32'h0);
      check("rst_tmo",   {31'd0, tmo}, 32'h0);
      check("rst_rdata", wb_rdata, 32'h0);
      check("rst_stall", {31'd0, wb_stall}, 32'h0);
      rst = 1'b0;
      tick();

      // Zero-wait read from slave 1
      s_rdata[63:32] = 32'hDEAD_BEEF;
      req(32'h1000_0004, 1'b0, 32'h0, 4'hF);
      check("rd_stb_n1",   {28'd0, s_stb}, 32'h2);
      check("rd_cyc_n1",   {28'd0, s_cyc}, 32'h2);
      check("rd_addr",     s_addr, 32'h1000_0004);
      check("rd_stall_n1", {31'd0, wb_stall}, 32'h1);
      tick();
      s_ack[1] = 1'b1;
      check("rd_stb_n2", {28'd0, s_stb}, 32'h0);
      check("rd_ack_n2", {31'd0, wb_ack}, 32'h0);
      tick();
      s_ack = '0;
      check("rd_ack_n3",   {31'd0, wb_ack}, 32'h1);
      check("rd_data_n3",  wb_rdata, 32'hDEAD_BEEF);
      check("rd_cyc_n3",   {28'd0, s_cyc}, 32'h0);
      check("rd_stall_n3", {31'd0, wb_stall}, 32'h0);
      tick();
      check("rd_ack_n4", {31'd0, wb_ack}, 32'h0);
      cyc = 1'b0;
      tick();

      // Write to slave 2 which stalls for three cycles
      s_stall[2] = 1'b1;
      req(32'h2000_0000, 1'b1, 32'hCAFE_0001, 4'b0011);
      check("wr_stb_n1", {28'd0, s_stb}, 32'h4);
      tick();
      check("wr_stb_n2", {28'd0, s_stb}, 32'h4);
      tick();
      check("wr_stb_n3", {28'd0, s_stb}, 32'h4);
      tick();
      s_stall = '0;
      check("wr_stb_n4", {28'd0, s_stb}, 32'h4);
      check("wr_we_n4",  {31'd0, s_we}, 32'h1);
      check("wr_sel_n4", {28'd0, s_sel}, 32'h3);
      check("wr_data",   s_wdata, 32'hCAFE_0001);
      check("wr_ack_n4", {31'd0, wb_ack}, 32'h0);
      tick();
      s_ack[2] = 1'b1;
      check("wr_stb_n5", {28'd0, s_stb}, 32'h0);
      check("wr_cyc_n5", {28'd0, s_cyc}, 32'h4);
      check("wr_we_n5",  {31'd0, s_we}, 32'h1);
      check("wr_sel_n5", {28'd0, s_sel}, 32'h3);
      tick();
      s_ack = '0;
      check("wr_ack_n6", {31'd0, wb_ack}, 32'h1);
      check("wr_err_n6", {31'd0, wb_err}, 32'h0);
      tick();
      check("wr_ack_n7", {31'd0, wb_ack}, 32'h0);
      cyc = 1'b0;
      tick();

      // Unmapped address
      req(32'hF000_0000, 1'b0, 32'h0, 4'hF);
      check("um_err_n1",   {31'd0, wb_err}, 32'h1);
      check("um_cyc_n1",   {28'd0, s_cyc}, 32'h0);
      check("um_stall_n1", {31'd0, wb_stall}, 32'h1);
      check("um_tmo_n1",   {31'd0, tmo}, 32'h0);
      tick();
      check("um_err_n2",   {31'd0, wb_err}, 32'h0);
      check("um_stall_n2", {31'd0, wb_stall}, 32'h0);
      cyc = 1'b0;
      tick();

      // Slave 0 never answers: watchdog at N+9 with TIMEOUT=8
      req(32'h0000_0100, 1'b0, 32'h0, 4'hF);
      for (int i = 2; i <= 8; i++) tick();
      check("to_err_n8", {31'd0, wb_err}, 32'h0);
      check("to_cyc_n8", {28'd0, s_cyc}, 32'h1);
      tick();
      check("to_err_n9", {31'd0, wb_err}, 32'h1);
      check("to_tmo_n9", {31'd0, tmo}, 32'h1);
      check("to_cyc_n9", {28'd0, s_cyc}, 32'h0);
      check("to_ack_n9", {31'd0, wb_ack}, 32'h0);
      tick();
      check("to_tmo_n10", {31'd0, tmo}, 32'h0);
      check("to_err_n10", {31'd0, wb_err}, 32'h0);
      cyc = 1'b0;
      tick();

      // Master abort during WAIT; stray ack from slave 0 must be ignored
      req(32'h1000_0000, 1'b0, 32'h0, 4'hF);
      tick();
      s_ack[0] = 1'b1;
      tick();
      s_ack = '0;
      check("ab_stray_ack", {31'd0, wb_ack}, 32'h0);
      check("ab_cyc_n3",    {28'd0, s_cyc}, 32'h2);
      cyc = 1'b0;
      tick();
      check("ab_cyc_n4", {28'd0, s_cyc}, 32'h0);
      check("ab_ack_n4", {31'd0, wb_ack}, 32'h0);
      check("ab_err_n4", {31'd0, wb_err}, 32'h0);
      tick();
      check("ab_ack_n5", {31'd0, wb_ack}, 32'h0);
      check("ab_err_n5", {31'd0, wb_err}, 32'h0);

      // Follow-up request to slave 3
      s_rdata[127:96] = 32'h3333_0000;
      req(32'h3000_0010, 1'b0, 32'h0, 4'hF);
      check("s3_stb_n1", {28'd0, s_stb}, 32'h8);
      tick();
      s_ack[3] = 1'b1;
      tick();
      s_ack = '0;
      check("s3_ack_n3",  {31'd0, wb_ack}, 32'h1);
      check("s3_data_n3", wb_rdata, 32'h3333_0000);
      cyc = 1'b0;
      tick();

      // Ack and err together: err wins
      req(32'h0000_0000, 1'b0, 32'h0, 4'hF);
      tick();
      s_ack[0] = 1'b1;
      s_err[0] = 1'b1;
      tick();
      s_ack = '0;
      s_err = '0;
      check("ae_err", {31'd0, wb_err}, 32'h1);
      check("ae_ack", {31'd0, wb_ack}, 32'h0);
      check("ae_tmo", {31'd0, tmo}, 32'h0);
      cyc = 1'b0;
      tick();

      // Ack on the final timer count beats the watchdog
      s_rdata[31:0] = 32'h0BAD_F00D;
      req(32'h0000_0004, 1'b0, 32'h0, 4'hF);
      for (int i = 2; i <= 7; i++) tick();
      tick();
      s_ack[0] = 1'b1;
      check("fc_err_n8", {31'd0, wb_err}, 32'h0);
      tick();
      s_ack = '0;
      check("fc_ack_n9",  {31'd0, wb_ack}, 32'h1);
      check("fc_err_n9",  {31'd0, wb_err}, 32'h0);
      check("fc_tmo_n9",  {31'd0, tmo}, 32'h0);
      check("fc_data_n9", wb_rdata, 32'h0BAD_F00D);
      cyc = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
